// File: rtl/xgmii_rx_measure_if.sv
`default_nettype none
// ============================================================================
//  Module      : xgmii_rx_measure_if
//  Description : XGMII receive bus (64-bit data + 8 per-lane control flags).
//                Lane i occupies rxd[8i+7:8i]; lane 0 is first on the wire.
//                master drives the bus, slave (the measurement block) samples.
//  Revision    : 1.0 - initial release
// ============================================================================
interface xgmii_rx_measure_if;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;

    modport master (output xgmii_rxd, output xgmii_rxc);
    modport slave  (input  xgmii_rxd, input  xgmii_rxc);
endinterface
`default_nettype wire

// File: rtl/xgmii_rx_measure.sv
`default_nettype none
// ============================================================================
//  Module      : xgmii_rx_measure
//  Description : Parses XGMII RX words, recognises test-generator frames by
//                their magic code and reports per-second frame/byte rates,
//                last one-way latency, last IPv4 destination and a running
//                count of magic-matched frames.
//  Ports       : sys_clk / sys_rst  - clock, synchronous active-high reset
//                sec_oneshot        - one-cycle strobe per second
//                global_counter     - shared timestamp base
//                rx (slave)         - XGMII rxd/rxc bus
//                rx_pps, rx_throughput, rx_latency, rx_ipv4_ip,
//                rx_magic_cnt       - registered measurement outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module xgmii_rx_measure #(
    parameter logic [31:0] MAGIC     = 32'hA5A5A5A5,
    parameter logic [15:0] MAX_WORDS = 16'd1200
) (
    input  wire logic               sys_clk,
    input  wire logic               sys_rst,
    input  wire logic               sec_oneshot,
    input  wire logic [31:0]        global_counter,
    xgmii_rx_measure_if.slave       rx,
    output logic [31:0]             rx_pps,
    output logic [31:0]             rx_throughput,
    output logic [23:0]             rx_latency,
    output logic [31:0]             rx_ipv4_ip,
    output logic [31:0]             rx_magic_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] w_q;                       // index of the word now on the bus
    logic        ipv4_q, dst_ok_q, magic_q, lat_ok_q;
    logic        ipv4_d, dst_ok_d, magic_d, lat_ok_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] ts_hi_q, ts_hi_d;
    logic [23:0] lat_q, lat_d;
    logic [31:0] pps_acc_q, byte_acc_q;
    logic [31:0] rx_pps_q, rx_tp_q, rx_ip_q, rx_mc_q;
    logic [23:0] rx_lat_q;

    // ---------------------------------------------------------------- decode
    logic        w_start, w_all_ctl, w_found, w_term, w_err, w_over, w_good;
    logic [2:0]  w_lane;
    logic [31:0] w_bytes, w_diff;
    logic [32:0] w_byte_sum;
    logic [63:0] w_d;
    logic [7:0]  w_c;

    assign w_d       = rx.xgmii_rxd;
    assign w_c       = rx.xgmii_rxc;
    assign w_start   = w_c[0] && (w_d[7:0] == 8'hFB);
    assign w_all_ctl = &w_c;
    assign w_over    = (w_q > MAX_WORDS);

    // The first control lane decides: FD ends the frame, anything else is an
    // error. Control lanes after FD are idle fill and are ignored.
    always_comb begin
        w_found = 1'b0;
        w_term  = 1'b0;
        w_err   = 1'b0;
        w_lane  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!w_found && w_c[i]) begin
                w_found = 1'b1;
                w_lane  = i[2:0];
                if (w_d[8*i +: 8] == 8'hFD) w_term = 1'b1;
                else                        w_err  = 1'b1;
            end
        end
    end

    assign w_good     = (state_q == S_FRAME) && !w_start && !w_over && w_term;
    assign w_bytes    = {13'd0, w_q - 16'd1, 3'd0} + {29'd0, w_lane};
    assign w_byte_sum = {1'b0, byte_acc_q} + {1'b0, w_bytes};
    assign w_diff     = global_counter - {ts_hi_q, w_d[7:0], w_d[15:8]};

    // Field staging. The next-state values already include the word on the
    // bus, so a frame terminating in the same word still commits correctly.
    always_comb begin
        ipv4_d   = ipv4_q;
        dst_d    = dst_q;
        dst_ok_d = dst_ok_q;
        magic_d  = magic_q;
        ts_hi_d  = ts_hi_q;
        lat_d    = lat_q;
        lat_ok_d = lat_ok_q;
        if (w_start) begin
            ipv4_d   = 1'b0;
            dst_d    = 32'd0;
            dst_ok_d = 1'b0;
            magic_d  = 1'b0;
            ts_hi_d  = 16'd0;
            lat_d    = 24'd0;
            lat_ok_d = 1'b0;
        end else if (state_q == S_FRAME) begin
            case (w_q)
                16'd2: ipv4_d = (w_d[39:32] == 8'h08) && (w_d[47:40] == 8'h00);
                16'd4: dst_d[31:16] = {w_d[55:48], w_d[63:56]};
                16'd5: begin
                    dst_d[15:0] = {w_d[7:0], w_d[15:8]};
                    dst_ok_d    = 1'b1;
                end
                16'd6: begin
                    magic_d = ({w_d[23:16], w_d[31:24], w_d[39:32], w_d[47:40]} == MAGIC);
                    ts_hi_d = {w_d[55:48], w_d[63:56]};
                end
                16'd7: begin
                    lat_d    = (w_diff[31:24] == 8'd0) ? w_diff[23:0] : 24'hFFFFFF;
                    lat_ok_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------ sequential
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            w_q        <= 16'd0;
            ipv4_q     <= 1'b0;
            dst_q      <= 32'd0;
            dst_ok_q   <= 1'b0;
            magic_q    <= 1'b0;
            ts_hi_q    <= 16'd0;
            lat_q      <= 24'd0;
            lat_ok_q   <= 1'b0;
            pps_acc_q  <= 32'd0;
            byte_acc_q <= 32'd0;
            rx_pps_q   <= 32'd0;
            rx_tp_q    <= 32'd0;
            rx_lat_q   <= 24'd0;
            rx_ip_q    <= 32'd0;
            rx_mc_q    <= 32'd0;
        end else begin
            ipv4_q   <= ipv4_d;
            dst_q    <= dst_d;
            dst_ok_q <= dst_ok_d;
            magic_q  <= magic_d;
            ts_hi_q  <= ts_hi_d;
            lat_q    <= lat_d;
            lat_ok_q <= lat_ok_d;

            case (state_q)
                S_IDLE: begin
                    if (w_start) begin
                        state_q <= S_FRAME;
                        w_q     <= 16'd1;
                    end
                end
                S_FRAME: begin
                    if (w_start) begin
                        w_q <= 16'd1;           // abort current, begin anew
                    end else if (w_over || w_err) begin
                        state_q <= S_DROP;
                    end else if (w_term) begin
                        state_q <= S_IDLE;
                    end else begin
                        w_q <= w_q + 16'd1;
                    end
                end
                S_DROP: begin
                    if (w_start) begin
                        state_q <= S_FRAME;
                        w_q     <= 16'd1;
                    end else if (w_all_ctl) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (w_good) begin
                if (lat_ok_d && magic_d && ipv4_d) begin
                    rx_lat_q <= lat_d;
                    rx_mc_q  <= rx_mc_q + 32'd1;
                end
                if (ipv4_d && dst_ok_d) rx_ip_q <= dst_d;
            end

            // A frame ending on the strobe cycle belongs to the new window.
            if (sec_oneshot) begin
                rx_pps_q   <= pps_acc_q;
                rx_tp_q    <= byte_acc_q;
                pps_acc_q  <= w_good ? 32'd1 : 32'd0;
                byte_acc_q <= w_good ? w_bytes : 32'd0;
            end else if (w_good) begin
                pps_acc_q  <= (pps_acc_q == 32'hFFFFFFFF) ? pps_acc_q : pps_acc_q + 32'd1;
                byte_acc_q <= w_byte_sum[32] ? 32'hFFFFFFFF : w_byte_sum[31:0];
            end
        end
    end

    assign rx_pps        = rx_pps_q;
    assign rx_throughput = rx_tp_q;
    assign rx_latency    = rx_lat_q;
    assign rx_ipv4_ip    = rx_ip_q;
    assign rx_magic_cnt  = rx_mc_q;

endmodule
`default_nettype wire

// File: tb/tb_xgmii_rx_measure.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xgmii_rx_measure
//  Description : Self-checking bench for xgmii_rx_measure. Frames are built
//                as byte arrays and serialised onto XGMII; a frame-level model
//                tracks expected outputs and is compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xgmii_rx_measure;
    localparam logic [31:0] MAGIC     = 32'hA5A5A5A5;
    localparam int          MAX_WORDS = 1200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sec = 1'b0;
    logic [31:0] gc  = 32'd0;
    logic [31:0] rx_pps, rx_throughput, rx_ipv4_ip, rx_magic_cnt;
    logic [23:0] rx_latency;

    xgmii_rx_measure_if rxif ();

    xgmii_rx_measure #(.MAGIC(MAGIC), .MAX_WORDS(16'd1200)) dut (
        .sys_clk        (clk),
        .sys_rst        (rst),
        .sec_oneshot    (sec),
        .global_counter (gc),
        .rx             (rxif.slave),
        .rx_pps         (rx_pps),
        .rx_throughput  (rx_throughput),
        .rx_latency     (rx_latency),
        .rx_ipv4_ip     (rx_ipv4_ip),
        .rx_magic_cnt   (rx_magic_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // frame-level reference model
    logic [31:0] m_pps = 0, m_tp = 0, m_ip = 0, m_mc = 0;
    logic [23:0] m_lat = 0;
    longint      acc_p = 0, acc_b = 0;
    logic [31:0] gc_val = 32'd100;
    bit          sec_rand_en = 1'b0;
    bit          cmp_en      = 1'b0;

    bit          cur_good = 1'b0, cur_ipv4 = 1'b0, cur_magic = 1'b0;
    int          cur_n = 0;
    logic [31:0] cur_dst = 0, cur_ts_off = 0;
    logic [7:0]  fb [0:9727];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rx_pps",        rx_pps,                m_pps);
            chk("rx_throughput", rx_throughput,         m_tp);
            chk("rx_latency",    {8'd0, rx_latency},    {8'd0, m_lat});
            chk("rx_ipv4_ip",    rx_ipv4_ip,            m_ip);
            chk("rx_magic_cnt",  rx_magic_cnt,          m_mc);
        end
    end

    task automatic model_step(input bit is_term);
        bit commit;
        if (rst) begin
            m_pps = 0; m_tp = 0; m_ip = 0; m_mc = 0; m_lat = 0;
            acc_p = 0; acc_b = 0;
            return;
        end
        commit = is_term && cur_good;
        if (sec) begin
            m_pps = acc_p[31:0];
            m_tp  = acc_b[31:0];
            acc_p = commit ? 1 : 0;
            acc_b = commit ? longint'(cur_n) : 0;
        end else if (commit) begin
            acc_p = (acc_p + 1 > 64'hFFFFFFFF) ? 64'hFFFFFFFF : acc_p + 1;
            acc_b = (acc_b + cur_n > 64'hFFFFFFFF) ? 64'hFFFFFFFF : acc_b + cur_n;
        end
        if (commit) begin
            if (cur_ipv4) m_ip = cur_dst;
            if (cur_ipv4 && cur_magic) begin
                m_lat = (cur_ts_off < 32'h01000000) ? cur_ts_off[23:0] : 24'hFFFFFF;
                m_mc  = m_mc + 1;
            end
        end
    endtask

    task automatic drive_word(input logic [63:0] d, input logic [7:0] c, input bit is_term,
                              input bit sec_force, input bit rst_force);
        #1;
        rxif.xgmii_rxd = d;
        rxif.xgmii_rxc = c;
        gc     = gc_val;
        gc_val = gc_val + 1;
        rst    = rst_force;
        sec    = sec_force | (sec_rand_en && ($urandom_range(0, 39) == 0));
        @(posedge clk);
        model_step(is_term);
    endtask

    task automatic idle(input int n, input bit sec_force);
        for (int i = 0; i < n; i++)
            drive_word(64'h0707070707070707, 8'hFF, 1'b0, sec_force, 1'b0);
    endtask

    // n = bytes from destination MAC through FCS; ts is chosen so that the
    // one-way latency seen at w7 equals ts_off.
    task automatic send_frame(input int n, input bit ipv4, input logic [31:0] dst,
                              input bit magic_ok, input logic [31:0] ts_off,
                              input int err_w, input int trunc, input bit lane4,
                              input bit sec_term, input bit rst_last);
        logic [31:0] ts, mg;
        logic [63:0] d;
        logic [7:0]  c;
        int          wlast, wend;
        ts = gc_val + 32'd7 - ts_off;
        mg = magic_ok ? MAGIC : (MAGIC ^ ($urandom | 32'h1));
        for (int j = 0; j < n; j++) fb[j] = 8'($urandom);
        fb[12] = ipv4 ? 8'h08 : 8'h86;  fb[13] = ipv4 ? 8'h00 : 8'hDD;
        fb[30] = dst[31:24]; fb[31] = dst[23:16]; fb[32] = dst[15:8]; fb[33] = dst[7:0];
        fb[42] = mg[31:24];  fb[43] = mg[23:16];  fb[44] = mg[15:8];  fb[45] = mg[7:0];
        fb[46] = ts[31:24];  fb[47] = ts[23:16];  fb[48] = ts[15:8];  fb[49] = ts[7:0];
        wlast      = n / 8 + 1;
        wend       = (trunc != 0) ? trunc : wlast;
        cur_n      = n;
        cur_ipv4   = ipv4;
        cur_magic  = magic_ok;
        cur_dst    = dst;
        cur_ts_off = ts_off;
        cur_good   = !lane4 && (err_w == 0) && (trunc == 0) && (wlast <= MAX_WORDS);
        if (lane4) begin
            d = 64'hD5_55_55_FB_07070707; c = 8'h1F;
        end else begin
            d = 64'hD5_55_55_55_55_55_55_FB; c = 8'h01;
        end
        drive_word(d, c, 1'b0, 1'b0, 1'b0);
        for (int w = 1; w <= wend; w++) begin
            for (int l = 0; l < 8; l++) begin
                int j;
                j = 8 * (w - 1) + l;
                if (j < n)       begin d[8*l +: 8] = fb[j];  c[l] = 1'b0; end
                else if (j == n) begin d[8*l +: 8] = 8'hFD;  c[l] = 1'b1; end
                else             begin d[8*l +: 8] = 8'h07;  c[l] = 1'b1; end
            end
            if (w == err_w) begin d[7:0] = 8'hFE; c[0] = 1'b1; end
            drive_word(d, c, (w == wlast) && (trunc == 0), sec_term && (w == wlast),
                       rst_last && (w == wend));
        end
    endtask

    task automatic good64(input logic [31:0] dst, input logic [31:0] off);
        send_frame(64, 1'b1, dst, 1'b1, off, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rxif.xgmii_rxd = 64'h0707070707070707;
        rxif.xgmii_rxc = 8'hFF;
        drive_word(64'h0707070707070707, 8'hFF, 1'b0, 1'b0, 1'b1);
        cmp_en = 1'b1;
        drive_word(64'h0707070707070707, 8'hFF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("reset_pps", rx_pps, 32'd0);
        chk("reset_mc",  rx_magic_cnt, 32'd0);
        idle(2, 1'b0);

        // basic 64-byte frame with known timestamp
        gc_val = 32'h00001234 - 32'd7;
        good64(32'h0A001569, 32'h00000234);
        @(negedge clk);
        chk("t1_latency", {8'd0, rx_latency}, 32'h00000234);
        chk("t1_magic",   rx_magic_cnt, 32'd1);
        chk("t1_ip",      rx_ipv4_ip, 32'h0A001569);

        // 1000 back-to-back frames in one window, then an empty window
        idle(1, 1'b1);
        for (int i = 0; i < 1000; i++) good64(32'h0A000001 + i, 32'd10);
        idle(1, 1'b1);
        @(negedge clk);
        chk("t2_pps", rx_pps, 32'd1000);
        chk("t2_tp",  rx_throughput, 32'd64000);
        idle(3, 1'b0);
        idle(1, 1'b1);
        @(negedge clk);
        chk("t2_pps_empty", rx_pps, 32'd0);
        chk("t2_tp_empty",  rx_throughput, 32'd0);

        // latency saturation, then magic mismatch leaves latency alone
        good64(32'h0B000001, 32'h01000000);
        @(negedge clk);
        chk("t3_sat", {8'd0, rx_latency}, 32'h00FFFFFF);
        send_frame(64, 1'b1, 32'h0B000002, 1'b0, 32'd5, 0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_mismatch_lat", {8'd0, rx_latency}, 32'h00FFFFFF);
        chk("t3_mismatch_ip",  rx_ipv4_ip, 32'h0B000002);

        // error byte at w4, then a clean frame
        send_frame(64, 1'b1, 32'h0C000001, 1'b1, 32'd7, 4, 0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        @(negedge clk);
        chk("t4_err_mc", rx_magic_cnt, 32'd1002);
        chk("t4_err_ip", rx_ipv4_ip, 32'h0B000002);
        good64(32'h0C000002, 32'h10);
        @(negedge clk);
        chk("t4_good_lat", {8'd0, rx_latency}, 32'h10);

        // 77-byte frame (lane 5 of w10) and terminate coinciding with strobe
        idle(1, 1'b1);
        send_frame(77, 1'b1, 32'h0D000001, 1'b0, 32'd1, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1);
        @(negedge clk);
        chk("t5_tp77", rx_throughput, 32'd77);
        send_frame(77, 1'b1, 32'h0D000002, 1'b0, 32'd1, 0, 0, 1'b0, 1'b0, 1'b0);
        send_frame(64, 1'b1, 32'h0D000003, 1'b0, 32'd1, 0, 0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t5_coin_pps", rx_pps, 32'd1);
        chk("t5_coin_tp",  rx_throughput, 32'd77);
        idle(1, 1'b1);
        @(negedge clk);
        chk("t5_next_pps", rx_pps, 32'd1);
        chk("t5_next_tp",  rx_throughput, 32'd64);

        // start in lane 4 ignored; aborted frame restarted by a new start
        send_frame(64, 1'b1, 32'h0E000001, 1'b1, 32'd3, 0, 0, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b1);
        @(negedge clk);
        chk("t6_lane4_pps", rx_pps, 32'd0);
        send_frame(64, 1'b1, 32'h0E000002, 1'b1, 32'd3, 0, 5, 1'b0, 1'b0, 1'b0);
        good64(32'h0E000003, 32'd4);
        idle(1, 1'b1);
        @(negedge clk);
        chk("t6_abort_pps", rx_pps, 32'd1);

        // reset mid-frame at w3
        send_frame(64, 1'b1, 32'h0F000001, 1'b1, 32'd3, 0, 3, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t6_rst_pps", rx_pps, 32'd0);
        chk("t6_rst_lat", {8'd0, rx_latency}, 32'd0);
        chk("t6_rst_mc",  rx_magic_cnt, 32'd0);
        idle(1, 1'b0);
        good64(32'hC0A80101, 32'h42);
        @(negedge clk);
        chk("t6_after_ip",  rx_ipv4_ip, 32'hC0A80101);
        chk("t6_after_lat", {8'd0, rx_latency}, 32'h42);
        chk("t6_after_mc",  rx_magic_cnt, 32'd1);

        // frame length limit
        idle(1, 1'b1);
        send_frame(8 * (MAX_WORDS - 1), 1'b1, 32'h10000001, 1'b1, 32'd9, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        send_frame(8 * MAX_WORDS, 1'b1, 32'h10000002, 1'b1, 32'd9, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1);
        @(negedge clk);
        chk("t7_max_pps", rx_pps, 32'd1);
        chk("t7_max_tp",  rx_throughput, 32'd9592);

        // randomized traffic with random strobes
        sec_rand_en = 1'b1;
        for (int i = 0; i < 250; i++) begin
            int          n, wl, err_w, trunc;
            logic [31:0] off;
            n  = $urandom_range(64, 200);
            wl = n / 8 + 1;
            err_w = ($urandom_range(0, 7) == 0) ? $urandom_range(1, wl - 1) : 0;
            trunc = ($urandom_range(0, 15) == 0) ? $urandom_range(1, wl - 1) : 0;
            case ($urandom_range(0, 3))
                0:       off = $urandom_range(0, 5000);
                1:       off = 32'h00FFFFFF;
                2:       off = 32'h01000000;
                default: off = $urandom;
            endcase
            send_frame(n, $urandom_range(0, 7) != 0, $urandom, $urandom_range(0, 3) != 0,
                       off, err_w, trunc, $urandom_range(0, 15) == 0, 1'b0, 1'b0);
            idle($urandom_range(0, 2), 1'b0);
        end
        sec_rand_en = 1'b0;
        idle(1, 1'b1);
        idle(2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
